// File: rtl/steer_pkg.sv
// ============================================================================
//  Module   : steer_pkg
//  Purpose  : Shared types and helpers for the steer_pid_gen2 steering block.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package steer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RAMP   = 2'd1,
        CRUISE = 2'd2,
        DECEL  = 2'd3
    } fsm_state_e;

    localparam int PID_W  = 17;
    localparam int CALC_W = 32;

    // Clamp a signed value into the range of a signed field of the given width.
    function automatic logic signed [CALC_W-1:0] sat_signed(
        input logic signed [CALC_W-1:0] val,
        input int                       width
    );
        logic signed [CALC_W-1:0] hi;
        logic signed [CALC_W-1:0] lo;
        hi = (32'sd1 <<< (width - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        if (val > hi)
            return hi;
        else if (val < lo)
            return lo;
        else
            return val;
    endfunction

endpackage

`default_nettype wire

// File: rtl/steer_fwd_ramp.sv
// ============================================================================
//  Module   : steer_fwd_ramp
//  Purpose  : Forward-speed FSM: ramps up, cruises, decelerates on line loss.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module steer_fwd_ramp
    import steer_pkg::*;
#(
    parameter int SPD_W     = 12,
    parameter int STEP      = 4,
    parameter int MAX_FRWRD = 'h300,
    parameter int MOVE_THR  = 'h080
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
    input  logic             line_present,
    input  logic             err_vld,
    output logic [SPD_W-1:0] frwrd,
    output logic             moving
);

    localparam logic [SPD_W-1:0] STEP_V = SPD_W'(STEP);
    localparam logic [SPD_W-1:0] MAX_V  = SPD_W'(MAX_FRWRD);
    localparam logic [SPD_W-1:0] THR_V  = SPD_W'(MOVE_THR);

    fsm_state_e       state;
    fsm_state_e       state_nxt;
    logic [SPD_W-1:0] frwrd_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            frwrd <= '0;
        end else begin
            state <= state_nxt;
            frwrd <= frwrd_nxt;
        end
    end

    // Line loss is checked before the speed step so it wins over reaching cruise.
    always_comb begin
        state_nxt = state;
        frwrd_nxt = frwrd;
        if (!go) begin
            state_nxt = IDLE;
            frwrd_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    frwrd_nxt = '0;
                    if (line_present)
                        state_nxt = RAMP;
                end
                RAMP: begin
                    if (!line_present) begin
                        state_nxt = DECEL;
                    end else if (err_vld) begin
                        if (frwrd >= MAX_V - STEP_V) begin
                            frwrd_nxt = MAX_V;
                            state_nxt = CRUISE;
                        end else begin
                            frwrd_nxt = frwrd + STEP_V;
                        end
                    end
                end
                CRUISE: begin
                    if (!line_present)
                        state_nxt = DECEL;
                end
                DECEL: begin
                    if (line_present)
                        state_nxt = RAMP;
                    else if (frwrd == '0)
                        state_nxt = IDLE;
                    else if (err_vld)
                        frwrd_nxt = (frwrd > STEP_V) ? (frwrd - STEP_V) : '0;
                end
                default: begin
                    state_nxt = IDLE;
                    frwrd_nxt = '0;
                end
            endcase
        end
    end

    assign moving = (frwrd > THR_V);

endmodule

`default_nettype wire

// File: rtl/steer_pid_gen2.sv
// ============================================================================
//  Module   : steer_pid_gen2
//  Purpose  : PID line-follow steering with ramped forward speed and clamped
//             differential motor outputs.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module steer_pid_gen2
    import steer_pkg::*;
#(
    parameter int ERR_W     = 16,
    parameter int SAT_W     = 11,
    parameter int DSAT_W    = 8,
    parameter int INTEG_W   = 16,
    parameter int I_SHIFT   = 6,
    parameter int P_COEFF   = 6,
    parameter int D_COEFF   = 56,
    parameter int D_LAG     = 2,
    parameter int PID_SHIFT = 3,
    parameter int SPD_W     = 12,
    parameter int RAMP_STEP = 4,
    parameter int MAX_FRWRD = 'h300,
    parameter int MOVE_THR  = 'h080,
    parameter int FAST_SIM  = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [ERR_W-1:0] error,
    input  logic                    err_vld,
    input  logic                    go,
    input  logic                    line_present,
    output logic        [SPD_W-1:0] lft_speed,
    output logic        [SPD_W-1:0] rght_speed,
    output logic                    moving,
    output logic                    spd_vld
);

    localparam int STEP    = (FAST_SIM != 0) ? RAMP_STEP * 8 : RAMP_STEP;
    localparam int SPD_MAX = (1 << SPD_W) - 1;

    logic signed [SAT_W-1:0]   err_sat;
    logic signed [SAT_W-1:0]   hist [D_LAG];
    logic signed [DSAT_W-1:0]  d_sat;
    logic signed [PID_W-1:0]   p_term;
    logic signed [PID_W-1:0]   d_term;
    logic signed [PID_W-1:0]   i_ext;
    logic signed [PID_W-1:0]   pid;
    logic signed [PID_W-1:0]   steer;
    logic signed [INTEG_W-1:0] integ;
    logic signed [INTEG_W-1:0] err_integ;
    logic signed [INTEG_W-1:0] integ_sum;
    logic                      integ_ovf;
    logic                      integ_clr;
    logic                      line_prev;
    logic        [SPD_W-1:0]   frwrd;

    steer_fwd_ramp #(
        .SPD_W     (SPD_W),
        .STEP      (STEP),
        .MAX_FRWRD (MAX_FRWRD),
        .MOVE_THR  (MOVE_THR)
    ) u_ramp (
        .clk          (clk),
        .rst_n        (rst_n),
        .go           (go),
        .line_present (line_present),
        .err_vld      (err_vld),
        .frwrd        (frwrd),
        .moving       (moving)
    );

    assign err_sat = SAT_W'(sat_signed(CALC_W'(error), SAT_W));
    assign d_sat   = DSAT_W'(sat_signed(CALC_W'(err_sat) - CALC_W'(hist[D_LAG-1]), DSAT_W));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < D_LAG; i++)
                hist[i] <= '0;
        end else if (err_vld) begin
            hist[0] <= err_sat;
            for (int i = 1; i < D_LAG; i++)
                hist[i] <= hist[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_term <= '0;
            d_term <= '0;
        end else if (!go) begin
            p_term <= '0;
            d_term <= '0;
        end else if (err_vld) begin
            p_term <= PID_W'(CALC_W'(err_sat) * CALC_W'(P_COEFF));
            d_term <= PID_W'(CALC_W'(d_sat) * CALC_W'(D_COEFF));
        end
    end

    // Overflow means both operands share a sign the sum does not: hold instead.
    assign err_integ = INTEG_W'(err_sat);
    assign integ_sum = integ + err_integ;
    assign integ_ovf = (integ[INTEG_W-1] == err_integ[INTEG_W-1]) &&
                       (integ_sum[INTEG_W-1] != integ[INTEG_W-1]);
    assign integ_clr = (line_present && !line_prev) || !go || !moving;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            integ     <= '0;
            line_prev <= 1'b0;
            spd_vld   <= 1'b0;
        end else begin
            line_prev <= line_present;
            spd_vld   <= err_vld;
            if (integ_clr)
                integ <= '0;
            else if (err_vld && !integ_ovf)
                integ <= integ_sum;
        end
    end

    assign i_ext = PID_W'($signed(integ[INTEG_W-1:I_SHIFT]));
    assign pid   = go ? (p_term + i_ext + d_term) : '0;
    assign steer = pid >>> PID_SHIFT;

    function automatic logic [SPD_W-1:0] clamp_spd(input logic signed [CALC_W-1:0] v);
        if (v < 0)
            return '0;
        else if (v > CALC_W'(SPD_MAX))
            return '1;
        else
            return SPD_W'(v);
    endfunction

    assign lft_speed  = moving ? clamp_spd($signed(CALC_W'(frwrd)) + CALC_W'(steer)) : frwrd;
    assign rght_speed = moving ? clamp_spd($signed(CALC_W'(frwrd)) - CALC_W'(steer)) : frwrd;

endmodule

`default_nettype wire

// File: tb/tb_steer_pid_gen2.sv
// ============================================================================
//  Module   : tb_steer_pid_gen2
//  Purpose  : Directed self-checking bench for steer_pid_gen2.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_steer_pid_gen2;
    import steer_pkg::*;

    logic               clk;
    logic               rst_n;
    logic signed [15:0] error;
    logic               err_vld;
    logic               go;
    logic               line_present;
    logic [11:0]        lft_speed;
    logic [11:0]        rght_speed;
    logic               moving;
    logic               spd_vld;

    int checks = 0;
    int errors = 0;

    steer_pid_gen2 dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .error        (error),
        .err_vld      (err_vld),
        .go           (go),
        .line_present (line_present),
        .lft_speed    (lft_speed),
        .rght_speed   (rght_speed),
        .moving       (moving),
        .spd_vld      (spd_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One error sample, strobe held for a single clock; returns on the
    // falling edge right after the capturing rising edge.
    task automatic send(input logic signed [15:0] e);
        repeat (2) @(negedge clk);
        error   = e;
        err_vld = 1'b1;
        @(negedge clk);
        err_vld = 1'b0;
    endtask

    initial begin
        rst_n        = 1'b0;
        error        = '0;
        err_vld      = 1'b0;
        go           = 1'b0;
        line_present = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_lft",    32'(lft_speed), 32'd0);
        chk("rst_rght",   32'(rght_speed), 32'd0);
        chk("rst_moving", 32'(moving), 32'd0);
        chk("rst_spdvld", 32'(spd_vld), 32'd0);
        chk("rst_state",  32'(dut.u_ramp.state), 32'(IDLE));
        rst_n = 1'b1;

        // Ramp from standstill to cruise with zero error
        @(negedge clk);
        go           = 1'b1;
        line_present = 1'b1;
        @(negedge clk);
        chk("to_ramp", 32'(dut.u_ramp.state), 32'(RAMP));
        for (int i = 1; i <= 192; i++) begin
            send(16'sd0);
            if (i == 32) begin
                chk("s32_frwrd",  32'(dut.frwrd), 32'h080);
                chk("s32_moving", 32'(moving), 32'd0);
            end
            if (i == 33) begin
                chk("s33_moving", 32'(moving), 32'd1);
                chk("s33_lft",    32'(lft_speed), 32'h084);
                chk("s33_rght",   32'(rght_speed), 32'h084);
                chk("s33_spdvld", 32'(spd_vld), 32'd1);
            end
        end
        chk("cruise_state", 32'(dut.u_ramp.state), 32'(CRUISE));
        chk("cruise_frwrd", 32'(dut.frwrd), 32'h300);
        chk("cruise_eq",    32'(lft_speed), 32'(rght_speed));

        // Full-scale error in cruise with clean history
        send(16'sh7FFF);
        chk("big_spdvld", 32'(spd_vld), 32'd1);
        chk("big_lft",    32'(lft_speed), 32'h97A);
        chk("big_rght",   32'(rght_speed), 32'h000);
        chk("big_integ",  32'(dut.integ), 32'd1023);
        @(negedge clk);
        chk("spdvld_pulse", 32'(spd_vld), 32'd0);

        // Integrator saturation: 32 samples total of +1023, then hold
        for (int i = 0; i < 31; i++)
            send(16'sd1023);
        chk("integ_32",  32'(dut.integ), 32'd32736);
        chk("integ_lft", 32'(lft_speed), 32'h63F);
        chk("integ_rgt", 32'(rght_speed), 32'h000);
        send(16'sd1023);
        chk("integ_hold", 32'(dut.integ), 32'd32736);

        // Line loss in cruise, decelerate to 0x200, line returns
        @(negedge clk);
        line_present = 1'b0;
        error        = '0;
        @(negedge clk);
        chk("decel_state", 32'(dut.u_ramp.state), 32'(DECEL));
        for (int i = 0; i < 64; i++)
            send(16'sd0);
        chk("decel_frwrd", 32'(dut.frwrd), 32'h200);
        chk("decel_lft",   32'(lft_speed), 32'h23F);
        chk("decel_rght",  32'(rght_speed), 32'h1C1);
        line_present = 1'b1;
        @(negedge clk);
        chk("reramp_state", 32'(dut.u_ramp.state), 32'(RAMP));
        chk("reramp_integ", 32'(dut.integ), 32'd0);

        // go drops mid-ramp together with a negative full-scale sample
        send(16'sd0);
        send(16'sd0);
        chk("ramp_frwrd", 32'(dut.frwrd), 32'h208);
        @(negedge clk);
        go      = 1'b0;
        error   = 16'sh8000;
        err_vld = 1'b1;
        #1;
        chk("neg_sat", 32'(dut.err_sat), 32'hFFFF_FC00);
        @(negedge clk);
        err_vld = 1'b0;
        chk("stop_frwrd", 32'(dut.frwrd), 32'd0);
        chk("stop_lft",   32'(lft_speed), 32'd0);
        chk("stop_rght",  32'(rght_speed), 32'd0);
        chk("stop_state", 32'(dut.u_ramp.state), 32'(IDLE));
        chk("stop_integ", 32'(dut.integ), 32'd0);

        // Restart, ramp past the moving threshold, then reset mid-run
        error = '0;
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 40; i++)
            send(16'sd5);
        chk("run_frwrd", 32'(dut.frwrd), 32'h0A0);
        chk("run_integ", 32'(dut.integ), 32'd35);
        chk("run_lft",   32'(lft_speed), 32'h0A3);
        chk("run_rght",  32'(rght_speed), 32'h09D);
        chk("run_spdvld", 32'(spd_vld), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_lft",    32'(lft_speed), 32'd0);
        chk("mrst_rght",   32'(rght_speed), 32'd0);
        chk("mrst_moving", 32'(moving), 32'd0);
        chk("mrst_spdvld", 32'(spd_vld), 32'd0);
        chk("mrst_state",  32'(dut.u_ramp.state), 32'(IDLE));
        chk("mrst_integ",  32'(dut.integ), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
